// File: rtl/control_unit_v2_if.sv
// Datapath bundle between the control FSM and the accumulator datapath.
interface control_unit_v2_if #(
  parameter int OPC_W = 4
);
  logic [OPC_W-1:0] IR;
  logic             Enter;
  logic             mem_ready;
  logic             Aeq0;
  logic             Apos;
  logic             IRload;
  logic             JMPmux;
  logic             PCload;
  logic             Meminst;
  logic             MemWr;
  logic             Aload;
  logic             Halt;
  logic [1:0]       Asel;
  logic [1:0]       ALUop;
  logic             Illegal;
  logic [4:0]       state;

  modport master (
    input  IR, Enter, mem_ready, Aeq0, Apos,
    output IRload, JMPmux, PCload, Meminst,
    output MemWr, Aload, Halt, Asel, ALUop,
    output Illegal, state
  );

  modport slave (
    output IR, Enter, mem_ready, Aeq0, Apos,
    input  IRload, JMPmux, PCload, Meminst,
    input  MemWr, Aload, Halt, Asel, ALUop,
    input  Illegal, state
  );
endinterface

// File: rtl/control_unit_v2.sv
// Accumulator control FSM with mem_ready waits and illegal-opcode trap.
// Optional single-step mode: define SINGLE_STEP_EN.
module control_unit_v2 #(
  parameter int OPC_W       = 4,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic clock,
  input  logic reset,
`ifdef SINGLE_STEP_EN
  input  logic step,
`endif
  control_unit_v2_if.master bus
);

  typedef enum logic [4:0] {
    START  = 5'd0,
    FETCH  = 5'd1,
    DECODE = 5'd2,
    PAUSE  = 5'd3,
    TRAP   = 5'd7,
    LOAD   = 5'd16,
    STORE  = 5'd17,
    ADD    = 5'd18,
    SUB    = 5'd19,
    INPUT  = 5'd20,
    JZ     = 5'd21,
    JPOS   = 5'd22,
    HALT   = 5'd23,
    JMP    = 5'd24,
    JNEG   = 5'd25,
    AND    = 5'd26,
    OR     = 5'd27
  } state_t;

  state_t     st, nst;
  logic       enter_q;
  logic       enter_rise;
  logic [7:0] opc;

  logic       irload, jmpmux, pcload, meminst;
  logic       memwr, aload, halt, illegal;
  logic [1:0] asel, aluop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st      <= START;
      enter_q <= 1'b0;
    end else begin
      st      <= nst;
      enter_q <= bus.Enter;
    end
  end

  assign enter_rise = bus.Enter & ~enter_q;

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign step_rise = step & ~step_q;
`endif

  assign opc = 8'(bus.IR);

  always_comb begin
    nst     = st;
    irload  = 1'b0;
    jmpmux  = 1'b0;
    pcload  = 1'b0;
    meminst = 1'b0;
    memwr   = 1'b0;
    aload   = 1'b0;
    halt    = 1'b0;
    illegal = 1'b0;
    asel    = 2'b00;
    aluop   = 2'b00;
    unique case (st)
`ifdef SINGLE_STEP_EN
      START: nst = PAUSE;
      PAUSE: if (step_rise) nst = FETCH;
`else
      START: nst = FETCH;
`endif
      FETCH: begin
        irload = bus.mem_ready;
        pcload = bus.mem_ready;
        if (bus.mem_ready) nst = DECODE;
      end
      DECODE: begin
        meminst = 1'b1;
        unique case (opc)
          8'd0:    nst = LOAD;
          8'd1:    nst = STORE;
          8'd2:    nst = ADD;
          8'd3:    nst = SUB;
          8'd4:    nst = INPUT;
          8'd5:    nst = JZ;
          8'd6:    nst = JPOS;
          8'd7:    nst = HALT;
          8'd8:    nst = JMP;
          8'd9:    nst = JNEG;
          8'd10:   nst = AND;
          8'd11:   nst = OR;
          default: nst = TRAP;
        endcase
      end
      LOAD: begin
        asel  = 2'b10;
        aload = bus.mem_ready;
        if (bus.mem_ready) nst = START;
      end
      STORE: begin
        meminst = 1'b1;
        memwr   = 1'b1;
        if (bus.mem_ready) nst = START;
      end
      ADD, SUB, AND, OR: begin
        aluop = st[3] ? {1'b1, st[0]} : {1'b0, st[0]};
        aload = bus.mem_ready;
        if (bus.mem_ready) nst = START;
      end
      INPUT: begin
        asel  = 2'b01;
        aload = 1'b1;
        if (enter_rise) nst = START;
      end
      JZ, JPOS, JMP, JNEG: begin
        jmpmux = 1'b1;
        unique case (st)
          JZ:      pcload = bus.Aeq0;
          JPOS:    pcload = bus.Apos;
          JMP:     pcload = 1'b1;
          default: pcload = ~bus.Aeq0 & ~bus.Apos;
        endcase
        nst = START;
      end
      HALT: begin
        halt = 1'b1;
        if (!HALT_STICKY && enter_rise) nst = START;
      end
      TRAP: begin
        halt    = 1'b1;
        illegal = 1'b1;
      end
      default: nst = START;
    endcase
  end

  assign bus.IRload  = irload;
  assign bus.JMPmux  = jmpmux;
  assign bus.PCload  = pcload;
  assign bus.Meminst = meminst;
  assign bus.MemWr   = memwr;
  assign bus.Aload   = aload;
  assign bus.Halt    = halt;
  assign bus.Asel    = asel;
  assign bus.ALUop   = aluop;
  assign bus.Illegal = illegal;
  assign bus.state   = st;

endmodule
